fft_reorder: RTL and testbench
==============================

# fft_reorder

Output reorder buffer for the single-path delay-feedback FFT pipeline. It accepts the bit-reversed complex sample stream produced by the last radix-2 butterfly stage (op_r/op_i qualified by outvalid) and returns each N-point frame in natural order. Two ping-pong banks let the block capture frame k+1 while frame k is drained through a valid/ready handshake. It is the reader at the far end of the FFT datapath.

## Interface
- N, 64: FFT size, power of 2, minimum 4.
- LOG2N, 6: log2(N); must be consistent with N.
- DW, 24: sample width per real/imaginary component, two's complement.
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  sample present; driven by the last stage's outvalid. There is no backpressure toward the FFT.
- in_r, in_i  in  DW each  input sample, bit-reversed order within a frame.
- out_valid  out  1  output sample available.
- out_ready  in  1  consumer accepts the sample.
- out_r, out_i  out  DW each  output sample, natural order.
- out_last  out  1  high with the sample at index N-1.
- overflow  out  1  sticky; set when an input sample is dropped.

## Operation
- Storage: 2 banks × N entries × 2·DW bits. Per-bank full flag bank_full[1:0].
- Writer: wr_bank (1 bit), wr_cnt (LOG2N bits).
  - On in_valid with bank_full[wr_bank]=0: write {in_r,in_i} at address bitrev(wr_cnt) and increment wr_cnt.
  - When wr_cnt=N-1 on an accepted write: set bank_full[wr_bank], toggle wr_bank, wrap wr_cnt to 0.
- Drop case: in_valid with bank_full[wr_bank]=1 means the sample is discarded, overflow is set to 1, and wr_cnt is unchanged. Frame alignment is lost; recovery requires reset.
- Reader: rd_bank (1 bit), rd_cnt (LOG2N bits).
  - out_valid = bank_full[rd_bank].
  - out_r/out_i = entry rd_cnt of rd_bank.
  - out_last = out_valid & (rd_cnt=N-1).
  - A transfer occurs when out_valid & out_ready. It increments rd_cnt. On the last sample it clears bank_full[rd_bank], toggles rd_bank and wraps rd_cnt to 0.
- Simultaneous events: a write completing on one bank and a read completing on the other bank in the same cycle both take effect. The writer never targets a full bank and the reader never reads a non-full bank, so set and clear never hit the same flag.
- bitrev(x) reverses the LOG2N bits of x.
- No arithmetic is performed; data passes bit-exact.

## Timing
- Reset values: wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, bank_full=2'b00, overflow=0, out_valid=0, out_last=0. Storage contents are not reset. out_r/out_i are don't-care while out_valid=0.
- Latency: if the last sample of a frame is written at edge t, out_valid rises immediately after edge t and out data for index 0 is valid in that same cycle.
- out_r/out_i/out_last are combinational from registered state and storage. They have no combinational dependence on in_* or out_ready.
- Throughput: 1 sample/cycle sustained when out_ready is held at 1. Input may be continuous, with no gaps between frames.
- Output handshake: once out_valid is high, it and the data stay stable until accepted.
- Reset mid-frame: partial frames are discarded. The next in_valid after reset is index 0 of a new frame.

## Structure
- Package fft_pkg holds:
  - FFT_DW=24 and default N/LOG2N.
  - Butterfly state encodings: WAIT=2'b00, FIRST=2'b01, SECOND=2'b10, DISABLE=2'b11.
  - A bitrev function parameterised by LOG2N.
- Sub-module fft_pingpong_ram contains the two banks: one write port (bank, address, data, enable) and one asynchronous read port (bank, address). Counters and flags stay in fft_reorder.

## Test plan
- Reset check: after reset, overflow=0, out_valid=0, out_last=0.
- Natural order, N=8: drive in_r = 0,4,2,6,1,5,3,7 (in_i = 100+in_r) on consecutive cycles with out_ready=1. Required: out_r = 0..7 on 8 consecutive cycles, in_i matching, out_last only on value 7.
- Continuous frames, N=8: send 4 back-to-back frames with out_ready=1. Required: every frame comes out in natural order, with no bubbles after the first frame and overflow staying 0.
- Backpressure, N=8: hold out_ready=0 through two full input frames. Required: out_valid=1 with value 0 held stable. A 17th in_valid must set overflow=1 and leave both stored frames intact when later drained.
- Random out_ready at 50% with a single frame: output sequence is still 0..7, and out_r does not change while out_valid=1 and out_ready=0.
- Reset after 5 of 8 writes, then send a full frame: only that frame is output, correctly ordered.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT pipeline: default sizes, butterfly
// state encodings and the bit-reversal helper used by the reorder stage.
package fft_pkg;

    localparam int FFT_DW      = 24;
    localparam int FFT_N       = 64;
    localparam int FFT_LOG2N   = 6;

    // Widest index the bit-reversal helper supports.
    localparam int BITREV_MAXW = 16;

    // Radix-2 butterfly stage control states.
    typedef enum logic [1:0] {
        WAIT    = 2'b00,
        FIRST   = 2'b01,
        SECOND  = 2'b10,
        DISABLE = 2'b11
    } bf_state_t;

    // Reverse the low log2n bits of x; bits at and above log2n return zero.
    function automatic logic [BITREV_MAXW-1:0] bitrev(
        input logic [BITREV_MAXW-1:0] x,
        input int unsigned            log2n
    );
        logic [BITREV_MAXW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < BITREV_MAXW; i++) begin
            if (i < log2n) begin
                r[i] = x[log2n-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample store: one synchronous write port, one asynchronous
// read port. Bank select forms the top address bit.
module fft_pingpong_ram
    import fft_pkg::*;
#(
    parameter int N     = FFT_N,
    parameter int LOG2N = FFT_LOG2N,
    parameter int DW    = FFT_DW
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic              i_wr_bank,
    input  logic [LOG2N-1:0]  i_wr_addr,
    input  logic [2*DW-1:0]   i_wr_data,
    input  logic              i_rd_bank,
    input  logic [LOG2N-1:0]  i_rd_addr,
    output logic [2*DW-1:0]   o_rd_data
);

    logic [2*DW-1:0] r_mem [2*N];

    // Store one complex sample into the selected bank.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[{i_wr_bank, i_wr_addr}] <= i_wr_data;
        end
    end

    // Asynchronous read of the entry currently being drained.
    always_comb begin
        o_rd_data = r_mem[{i_rd_bank, i_rd_addr}];
    end

endmodule

// File: rtl/fft_reorder.sv
// Output reorder buffer: captures bit-reversed frames into ping-pong banks
// and drains them in natural order through a valid/ready handshake.
module fft_reorder
    import fft_pkg::*;
#(
    parameter int N     = FFT_N,
    parameter int LOG2N = FFT_LOG2N,
    parameter int DW    = FFT_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_r,
    input  logic [DW-1:0] in_i,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_r,
    output logic [DW-1:0] out_i,
    output logic          out_last,
    output logic          overflow
);

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N-1);

    logic             r_wr_bank;
    logic [LOG2N-1:0] r_wr_cnt;
    logic             r_rd_bank;
    logic [LOG2N-1:0] r_rd_cnt;
    logic [1:0]       r_full;
    logic             r_overflow;

    logic             w_wr_accept;
    logic             w_wr_drop;
    logic             w_wr_done;
    logic             w_rd_xfer;
    logic             w_rd_done;
    logic [1:0]       w_full_nxt;
    logic [LOG2N-1:0] w_wr_addr;
    logic [2*DW-1:0]  w_rd_data;

    // Handshake qualifiers for the writer and reader.
    always_comb begin
        w_wr_accept = in_valid & ~r_full[r_wr_bank];
        w_wr_drop   = in_valid &  r_full[r_wr_bank];
        w_wr_done   = w_wr_accept & (r_wr_cnt == LAST_IDX);
        w_rd_xfer   = r_full[r_rd_bank] & out_ready;
        w_rd_done   = w_rd_xfer & (r_rd_cnt == LAST_IDX);
        w_wr_addr   = LOG2N'(bitrev(BITREV_MAXW'(r_wr_cnt), LOG2N));
    end

    // Bank-full flags: writer sets its bank, reader clears its bank; they
    // always point at different banks when both complete together.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_done) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_rd_done) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    // Writer/reader counters, bank pointers, flags and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_bank  <= 1'b0;
            r_wr_cnt   <= '0;
            r_rd_bank  <= 1'b0;
            r_rd_cnt   <= '0;
            r_full     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_wr_accept) begin
                r_wr_cnt <= r_wr_cnt + LOG2N'(1);
            end
            if (w_wr_done) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_wr_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_rd_xfer) begin
                r_rd_cnt <= r_rd_cnt + LOG2N'(1);
            end
            if (w_rd_done) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    fft_pingpong_ram #(
        .N     (N),
        .LOG2N (LOG2N),
        .DW    (DW)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_accept),
        .i_wr_bank (r_wr_bank),
        .i_wr_addr (w_wr_addr),
        .i_wr_data ({in_r, in_i}),
        .i_rd_bank (r_rd_bank),
        .i_rd_addr (r_rd_cnt),
        .o_rd_data (w_rd_data)
    );

    // Output side is purely a function of registered state and storage.
    always_comb begin
        out_valid = r_full[r_rd_bank];
        out_last  = r_full[r_rd_bank] & (r_rd_cnt == LAST_IDX);
        out_r     = w_rd_data[2*DW-1:DW];
        out_i     = w_rd_data[DW-1:0];
        overflow  = r_overflow;
    end

endmodule

// File: tb/tb_fft_reorder.sv
// Self-checking bench for fft_reorder at N=8 against a frame-level model.
module tb_fft_reorder;

    localparam int N     = 8;
    localparam int LOG2N = 3;
    localparam int DW    = 24;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_r = '0;
    logic [DW-1:0] in_i = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_r;
    logic [DW-1:0] out_i;
    logic          out_last;
    logic          overflow;

    fft_reorder #(
        .N     (N),
        .LOG2N (LOG2N),
        .DW    (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_r      (in_r),
        .in_i      (in_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_i     (out_i),
        .out_last  (out_last),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] r;
        logic [DW-1:0] i;
        logic          last;
    } smp_t;

    // Model: samples of completed frames awaiting output, in natural order.
    smp_t          exp_q[$];
    logic [DW-1:0] part_r [N];
    logic [DW-1:0] part_i [N];
    int            part_cnt    = 0;
    int            frames_held = 0;
    logic          ovf_exp     = 1'b0;
    logic          stall_prev  = 1'b0;
    logic [DW-1:0] stall_r     = '0;

    int vectors    = 0;
    int miscompares = 0;

    function automatic int brev(input int x);
        int y = 0;
        for (int k = 0; k < LOG2N; k++) begin
            y = y * 2 + ((x >> k) & 1);
        end
        return y;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Check outputs before the edge, advance the model, clock, check overflow.
    task automatic cycle();
        smp_t h;
        logic xfer;
        int   idx;
        chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() > 0});
        if (stall_prev) chk("stall_hold", {40'd0, out_r}, {40'd0, stall_r});
        if (exp_q.size() > 0) begin
            h = exp_q[0];
            chk("out_r", {40'd0, out_r}, {40'd0, h.r});
            chk("out_i", {40'd0, out_i}, {40'd0, h.i});
            chk("out_last", {63'd0, out_last}, {63'd0, h.last});
        end else begin
            chk("out_last_idle", {63'd0, out_last}, 64'd0);
        end
        xfer       = (exp_q.size() > 0) && out_ready;
        stall_prev = (exp_q.size() > 0) && !out_ready;
        stall_r    = out_r;
        if (in_valid) begin
            if (frames_held < 2) begin
                idx = brev(part_cnt);
                part_r[idx] = in_r;
                part_i[idx] = in_i;
                part_cnt++;
                if (part_cnt == N) begin
                    for (int k = 0; k < N; k++) begin
                        h.r = part_r[k];
                        h.i = part_i[k];
                        h.last = (k == N - 1);
                        exp_q.push_back(h);
                    end
                    frames_held++;
                    part_cnt = 0;
                end
            end else begin
                ovf_exp = 1'b1;
            end
        end
        if (xfer) begin
            h = exp_q.pop_front();
            if (h.last) frames_held--;
        end
        @(posedge clk);
        #1;
        chk("overflow", {63'd0, overflow}, {63'd0, ovf_exp});
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        part_cnt    = 0;
        frames_held = 0;
        ovf_exp     = 1'b0;
        stall_prev  = 1'b0;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_last", {63'd0, out_last}, 64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
    endtask

    // Feed one frame in bit-reversed order; directed frames carry index values.
    task automatic send_frame(input bit directed, input bit rand_ready);
        for (int j = 0; j < N; j++) begin
            in_valid = 1'b1;
            if (directed) begin
                in_r = DW'(brev(j));
                in_i = DW'(100 + brev(j));
            end else begin
                in_r = DW'($urandom);
                in_i = DW'($urandom);
            end
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        in_valid = 1'b0;
    endtask

    task automatic send_partial(input int cnt);
        for (int j = 0; j < cnt; j++) begin
            in_valid = 1'b1;
            in_r = DW'($urandom);
            in_i = DW'($urandom);
            cycle();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input bit rand_ready, input int budget);
        int n = 0;
        in_valid = 1'b0;
        while (exp_q.size() > 0 && n < budget) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle();
            n++;
        end
        chk("drain_remaining", 64'(exp_q.size()), 64'd0);
        out_ready = 1'b1;
        cycle();
    endtask

    initial begin
        do_reset();

        // Single directed frame, consumer always ready.
        out_ready = 1'b1;
        send_frame(1'b1, 1'b0);
        drain(1'b0, 100);

        // Four back-to-back random frames.
        out_ready = 1'b1;
        repeat (4) send_frame(1'b0, 1'b0);
        drain(1'b0, 100);

        // Backpressure: two frames stored, a 17th sample is dropped.
        out_ready = 1'b0;
        send_frame(1'b0, 1'b0);
        send_frame(1'b0, 1'b0);
        send_partial(1);
        out_ready = 1'b0;
        repeat (3) cycle();
        drain(1'b0, 100);
        do_reset();

        // Random consumer readiness with one directed frame, then several random.
        send_frame(1'b1, 1'b1);
        drain(1'b1, 400);
        repeat (3) send_frame(1'b0, 1'b1);
        drain(1'b1, 400);
        do_reset();

        // Reset in the middle of a frame, then a full directed frame.
        out_ready = 1'b1;
        send_partial(5);
        do_reset();
        out_ready = 1'b1;
        send_frame(1'b1, 1'b0);
        drain(1'b0, 100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
